ball_sprite_engine: RTL
=======================

Name: ball_sprite_engine

Overview:
- Parametrised Motion Pong ball engine. It owns the frame timer, ball position and direction registers, and wall-bounce logic.
- It drives the VGA pixel stream to erase the ball at its old position, move it, and redraw it once per frame tick.
- Sits between the game control FSM (enable, colour, speed) and the VGA adapter (pixel plot handshake).
- Replaces the fixed 4x4, fixed-speed, 640x480 ball datapath with a self-sequenced engine.

Parameters:
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- X_W, 10, x coordinate width; must satisfy 2^X_W >= SCREEN_W.
- Y_W, 10, y coordinate width; must satisfy 2^Y_W >= SCREEN_H.
- SIZE, 4, ball edge length in pixels; power of two, 1..16.
- FRAME_TICKS, 833333, clocks per frame (60 Hz at 50 MHz).
- COLOUR_W, 3, colour width.
- BG_COLOUR, 0, erase colour.
- START_X, 0, reset x position.
- START_Y, 0, reset y position.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- enable  in  1  run the ball; when low, freeze after the current frame completes
- colour_in  in  COLOUR_W  ball colour, sampled at DRAW entry
- step  in  4  pixels moved per axis per frame; sampled at MOVE
- plot_ready  in  1  VGA adapter accepts the current pixel
- plot_valid  out  1  pixel on x_out/y_out/colour_out is valid
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- colour_out  out  COLOUR_W  pixel colour
- ball_x  out  X_W  current top-left x
- ball_y  out  Y_W  current top-left y
- hit_x  out  1  one-cycle pulse on a left or right wall bounce
- hit_y  out  1  one-cycle pulse on a top or bottom wall bounce
- frame_done  out  1  one-cycle pulse when DRAW completes
- overrun  out  1  one-cycle pulse when a tick arrives while one is already pending

Behaviour:
- Reset (resetn low at a clock edge):
  - state=WAIT; ball_x=START_X; ball_y=START_Y; x_dir=y_dir=1 (moving right/down).
  - Frame counter = FRAME_TICKS-1; pending=0; pixel counter=0.
  - All outputs 0. Reset mid-stream aborts the erase/draw immediately.
- Frame timer:
  - Counts down every clock regardless of state.
  - At 0: reloads FRAME_TICKS-1 and sets pending.
  - A tick while pending=1 pulses overrun; pending stays 1, so the extra tick is dropped.
- FSM states: WAIT, ERASE, MOVE, DRAW.
  - WAIT: if pending and enable, clear pending and go to ERASE. pending is cleared in the same cycle; a tick in that same cycle sets it again.
  - ERASE: SIZE*SIZE pixels at (ball_x+col, ball_y+row), colour BG_COLOUR.
  - MOVE: exactly one cycle, plot_valid=0; updates position, then go to DRAW with colour_in latched.
  - DRAW: same pixel sweep with the latched colour. After the last accepted pixel: pulse frame_done, go to WAIT.
- Pixel sweep:
  - Counter of width 2*log2(SIZE). col = low bits, row = high bits; row-major, col fastest.
  - plot_valid=1 throughout ERASE/DRAW. Counter advances only on plot_valid & plot_ready.
  - x_out/y_out/colour_out hold stable while plot_ready=0.
  - Last pixel is counter = SIZE*SIZE-1. One pixel per clock at best: latency = 2*SIZE*SIZE+1 clocks from leaving WAIT to frame_done.
- MOVE arithmetic, x axis (y identical with SCREEN_H/y_dir/hit_y). Compute at X_W+1 bits to avoid wrap.
  - x_dir=1: if ball_x+step >= SCREEN_W-SIZE, then ball_x=SCREEN_W-SIZE, x_dir=0, pulse hit_x. Else ball_x+=step.
  - x_dir=0: if ball_x <= step, then ball_x=0, x_dir=1, pulse hit_x. Else ball_x-=step.
  - step=0: no motion, no hit pulse, direction unchanged.
  - Exact landing on a wall counts as a hit.
  - A corner hit pulses hit_x and hit_y in the same cycle.
- enable low:
  - An in-progress ERASE/MOVE/DRAW completes.
  - The FSM then stays in WAIT; the timer keeps running and pending still latches.
  - When enable returns with pending=1, the frame starts at once.
- Ball always stays fully on screen: 0 <= ball_x <= SCREEN_W-SIZE.

Decomposition:
- Shared package pong_pkg:
  - ball_state_t enum (WAIT, ERASE, MOVE, DRAW).
  - Screen-size and 60 Hz FRAME_TICKS constants.
  - clog2 helper.
- One sub-module frame_tick_gen: parametrised down-counter with tick output. Used here and by the paddle engines.

Test Plan (SCREEN_W=16, SCREEN_H=12, SIZE=2, FRAME_TICKS=8, step=1, plot_ready=1 unless noted):
- Reset then run -> first ERASE starts at clock 8. Erase pixels (0,0),(1,0),(0,1),(1,1) with colour 0. MOVE to (1,1). DRAW same pattern offset to (1,1) with colour_in. frame_done is 9 clocks after ERASE start.
- Right-wall bounce: step=4 from ball_x=12, x_dir=1 -> ball_x=14, hit_x pulses 1 cycle, x_dir=0. Next frame ball_x=10.
- Corner: ball at (13,9), step=1, dirs=1 -> (14,10), hit_x and hit_y in the same cycle. Next frame (13,9).
- Backpressure: plot_ready toggles 0/1 each clock -> every pixel held stable while stalled, no pixel skipped or duplicated. frame_done at 17 clocks; a tick during the frame raises pending, no overrun.
- FRAME_TICKS=4 with plot_ready=0 for 10 clocks -> overrun pulses. Only one extra frame runs after the stall ends.
- enable dropped mid-DRAW -> DRAW completes, FSM holds WAIT. Re-enable -> ERASE begins the next cycle. resetn low mid-ERASE -> plot_valid=0 next cycle, position back to (0,0).

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Motion Pong definitions: FSM states, screen/frame defaults
// and a constant-width helper used by the ball and paddle engines.
package pong_pkg;

    typedef enum logic [1:0] {
        WAIT,
        ERASE,
        MOVE,
        DRAW
    } ball_state_t;

    localparam int SCREEN_W_DEF     = 640;
    localparam int SCREEN_H_DEF     = 480;
    localparam int FRAME_TICKS_60HZ = 833333;

    function automatic int clog2(input int v);
        int n;
        n = 0;
        while ((1 << n) < v) n++;
        return n;
    endfunction

endpackage

// File: rtl/ball_sprite_engine_if.sv
// Pixel plot handshake between a sprite engine and the VGA adapter.
interface ball_sprite_engine_if #(
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int COLOUR_W = 3
);
    logic                plot_valid;
    logic                plot_ready;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour_out;

    modport master (
        output plot_valid, x_out, y_out, colour_out,
        input  plot_ready
    );

    modport slave (
        input  plot_valid, x_out, y_out, colour_out,
        output plot_ready
    );
endinterface

// File: rtl/frame_tick_gen.sv
// Free-running down-counter; tick is high for the one clock
// in which the count sits at zero, then it reloads.
module frame_tick_gen
    import pong_pkg::*;
#(
    parameter int TICKS = FRAME_TICKS_60HZ
) (
    input  logic clock,
    input  logic resetn,
    output logic tick
);
    localparam int CW = (clog2(TICKS) > 0) ? clog2(TICKS) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!resetn)
            count <= CW'(TICKS - 1);
        else if (count == '0)
            count <= CW'(TICKS - 1);
        else
            count <= count - 1'b1;
    end

    assign tick = (count == '0);
endmodule

// File: rtl/ball_sprite_engine.sv
// Motion Pong ball: per-frame erase / move / redraw over the
// VGA plot handshake, with wall bounces and frame overrun flag.
module ball_sprite_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int SIZE        = 4,
    parameter int FRAME_TICKS = FRAME_TICKS_60HZ,
    parameter int COLOUR_W    = 3,
    parameter int BG_COLOUR   = 0,
    parameter int START_X     = 0,
    parameter int START_Y     = 0
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                enable,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic [3:0]          step,
    ball_sprite_engine_if.master plot,
    output logic [X_W-1:0]      ball_x,
    output logic [Y_W-1:0]      ball_y,
    output logic                hit_x,
    output logic                hit_y,
    output logic                frame_done,
    output logic                overrun
);
    localparam int XL   = SCREEN_W - SIZE;
    localparam int YL   = SCREEN_H - SIZE;
    localparam int LAST = SIZE * SIZE - 1;
    localparam int PW   = (2 * clog2(SIZE) > 0) ? 2 * clog2(SIZE) : 1;

    ball_state_t state, nxt;

    logic                x_dir, y_dir, pending;
    logic                tick, start, acc, last;
    logic [PW-1:0]       pix;
    logic [COLOUR_W-1:0] col_l;
    logic [X_W:0]        x_sum;
    logic [Y_W:0]        y_sum;
    logic [X_W-1:0]      nx;
    logic [Y_W-1:0]      ny;
    logic                nxd, nyd, hx, hy;

    frame_tick_gen #(.TICKS(FRAME_TICKS)) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .tick   (tick)
    );

    assign plot.plot_valid = (state == ERASE) || (state == DRAW);
    assign plot.x_out      = ball_x + X_W'(pix % SIZE);
    assign plot.y_out      = ball_y + Y_W'(pix / SIZE);
    assign plot.colour_out = (state == DRAW) ? col_l
                                             : COLOUR_W'(BG_COLOUR);

    assign acc  = plot.plot_valid & plot.plot_ready;
    assign last = (pix == PW'(LAST));

    always_ff @(posedge clock) begin
        if (!resetn) state <= WAIT;
        else         state <= nxt;
    end

    always_comb begin
        nxt   = state;
        start = 1'b0;
        unique case (state)
            WAIT:  if (pending && enable) begin
                       nxt   = ERASE;
                       start = 1'b1;
                   end
            ERASE: if (acc && last) nxt = MOVE;
            MOVE:  nxt = DRAW;
            DRAW:  if (acc && last) nxt = WAIT;
            default: nxt = WAIT;
        endcase
    end

    // Sums carry one extra bit so a large step never wraps past the wall.
    always_comb begin
        x_sum = {1'b0, ball_x} + (X_W+1)'(step);
        nx    = ball_x;
        nxd   = x_dir;
        hx    = 1'b0;
        if (step != 4'd0) begin
            if (x_dir) begin
                if (x_sum >= (X_W+1)'(XL)) begin
                    nx = X_W'(XL); nxd = 1'b0; hx = 1'b1;
                end else begin
                    nx = x_sum[X_W-1:0];
                end
            end else if ({1'b0, ball_x} <= (X_W+1)'(step)) begin
                nx = '0; nxd = 1'b1; hx = 1'b1;
            end else begin
                nx = ball_x - X_W'(step);
            end
        end
    end

    always_comb begin
        y_sum = {1'b0, ball_y} + (Y_W+1)'(step);
        ny    = ball_y;
        nyd   = y_dir;
        hy    = 1'b0;
        if (step != 4'd0) begin
            if (y_dir) begin
                if (y_sum >= (Y_W+1)'(YL)) begin
                    ny = Y_W'(YL); nyd = 1'b0; hy = 1'b1;
                end else begin
                    ny = y_sum[Y_W-1:0];
                end
            end else if ({1'b0, ball_y} <= (Y_W+1)'(step)) begin
                ny = '0; nyd = 1'b1; hy = 1'b1;
            end else begin
                ny = ball_y - Y_W'(step);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ball_x     <= X_W'(START_X);
            ball_y     <= Y_W'(START_Y);
            x_dir      <= 1'b1;
            y_dir      <= 1'b1;
            pending    <= 1'b0;
            pix        <= '0;
            col_l      <= '0;
            hit_x      <= 1'b0;
            hit_y      <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            hit_x      <= 1'b0;
            hit_y      <= 1'b0;
            frame_done <= 1'b0;
            // A tick consumed by this cycle's frame start is not dropped.
            overrun    <= tick & pending & ~start;
            if (tick)       pending <= 1'b1;
            else if (start) pending <= 1'b0;
            if (acc) pix <= last ? '0 : pix + 1'b1;
            if (state == MOVE) begin
                ball_x <= nx;
                ball_y <= ny;
                x_dir  <= nxd;
                y_dir  <= nyd;
                hit_x  <= hx;
                hit_y  <= hy;
                col_l  <= colour_in;
            end
            if (state == DRAW && acc && last) frame_done <= 1'b1;
        end
    end
endmodule
